mac_stage_engine: RTL and testbench
===================================

// Module: mac_stage_engine
// PURPOSE
//   Stage-side responder for the network sequencer's start/done protocol: the
//   sequencer strobes start, and this block computes one dense layer, then pulses done.
//   Sequential int8 MAC layer: out[j] = requant( sum_i in[i]*w[j*N_IN+i] ), j<N_OUT.
//   Inputs and weights come from synchronous 1-cycle-latency read ports. Outputs go to a write port.
//   Reusable body for the fc1-style stages and any later dense layer.
// PARAMETERS
//   N_IN   132  inputs per neuron (>=1)
//   N_OUT  10   neurons (>=1)
//   ACC_W  24   signed accumulator width, >= 16+clog2(N_IN)
//   SHIFT  0    arithmetic right shift applied to accumulator before saturation
//   RELU   1    1: clamp negative results to 0 after saturation
// PORTS
//   clk       in   1                   clock
//   rst       in   1                   reset
//   start     in   1                   run request, sampled only in IDLE
//   in_addr   out  clog2(N_IN)         input-vector read address
//   in_data   in   8 signed            in[in_addr of previous cycle]
//   w_addr    out  clog2(N_IN*N_OUT)   weight read address (= j*N_IN+i)
//   w_data    in   8 signed            w[w_addr of previous cycle]
//   out_we    out  1                   output write strobe
//   out_addr  out  clog2(N_OUT)        output index j
//   out_data  out  8 signed            requantized result
//   busy      out  1                   high in every state except IDLE
//   done      out  1                   single-cycle completion pulse
// BEHAVIOUR
//   Reset: rst is synchronous and active-high; clk is the clock.
//     When rst is asserted: state=IDLE; acc, i, j, all addresses, out_data=0; out_we=busy=done=0.
//   FSM: IDLE -> RUN -> DRAIN -> WRITE -> (RUN if j<N_OUT-1, else DONE) -> IDLE.
//     IDLE:  if start is high, clear acc, i and j, then go to RUN. Otherwise hold.
//     RUN:   drive in_addr=i and w_addr=j*N_IN+i.
//            When i>0, also do acc += in_data*w_data (product of the previous cycle's addresses).
//            i increments each cycle. After i=N_IN-1, go to DRAIN.
//     DRAIN: accumulate the last product. No new address is issued.
//     WRITE: out_we=1, out_addr=j, out_data=requant(acc) for exactly 1 cycle.
//            Then clear acc and i, increment j.
//     DONE:  done=1 for exactly 1 cycle, then return to IDLE.
//   Latency: if start is sampled at cycle t, neuron j is written at t+(j+1)*(N_IN+2).
//     done is high at t+N_OUT*(N_IN+2)+1.
//   Arithmetic:
//     product = 8sx8s -> 16 signed, sign-extended to ACC_W.
//     No overflow detection, because ACC_W is sized to hold the full sum.
//     requant: a = acc>>>SHIFT (floor). Saturate to [-128,127]. If RELU, max(0,.).
//   Handshake:
//     start is ignored outside IDLE; there is no queueing.
//     If start is still high in the cycle after DONE, it starts a new run from IDLE.
//     done never coincides with out_we.
//   Reset mid-operation: abort immediately, with no done and no further writes.
//     Output memory contents already written are left as they are.
//   Read ports: data must be valid exactly 1 cycle after the address.
//     Addresses are don't-care outside RUN, but are held at their last value.
// STRUCTURE
//   npu_pkg:
//     - int8/acc typedefs
//     - sat8 bounds (-128/127)
//     - FSM state encoding localparams (IDLE, RUN, DRAIN, WRITE, DONE)
//   Sub-module: requant_sat8 (combinational: acc, SHIFT, RELU -> int8).
//     Shared with conv stages.
//   Engine itself: FSM + i/j counters + accumulator + product register.
// TESTING  (N_IN=4, N_OUT=2, SHIFT=0 unless stated; models return data 1 cycle late)
//   1. in=[1,2,3,4], w0=[1,1,1,1], w1=[2,0,0,-1], RELU=0, start at t.
//      -> out[0]=10 at t+6, out[1]=-2 at t+12, done at t+13 only.
//   2. in=[127]*4, w0=[-128]*4 (acc=-65024), RELU=0 -> out[0]=-128.
//      w1=[127]*4 (acc=64516) -> out[1]=127.
//   3. Same as 2 with RELU=1 -> out[0]=0, out[1]=127.
//      SHIFT=4 with acc=40 -> out 2. SHIFT=4 with acc=-40, RELU=0 -> out -3.
//   4. start held high for the whole run -> exactly one write per j and one done pulse.
//      The next run begins at t+14 (IDLE cycle after DONE).
//   5. rst asserted at t+3 mid-run -> busy=0 and no out_we from t+4.
//      done never pulses. A fresh start then gives the result of scenario 1.
//   6. N_IN=132, N_OUT=10, all in=1, w=1, SHIFT=3
//      -> each out=16, done at t+1341, busy high for t+1..t+1341.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU stage types: int8 datapath types, saturation bounds and the
// stage-engine FSM state encoding.
package npu_pkg;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [15:0] prod16_t;

  localparam int8_t SAT8_MIN = 8'sh80;
  localparam int8_t SAT8_MAX = 8'sh7f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/requant_sat8.sv
// Requantizer shared by dense and conv stages: floor shift, saturate to int8,
// optional ReLU clamp.
module requant_sat8
  import npu_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 0,
  parameter bit          RELU  = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       q
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT8_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT8_MIN);

  logic signed [ACC_W-1:0] shifted;
  logic signed [7:0]       sat;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > HI) begin
      sat = SAT8_MAX;
    end else if (shifted < LO) begin
      sat = SAT8_MIN;
    end else begin
      sat = shifted[7:0];
    end
    q = (RELU && sat[7]) ? '0 : sat;
  end

endmodule

// File: rtl/mac_stage_engine.sv
// Dense int8 MAC stage: answers a start strobe by computing N_OUT requantized
// dot products from 1-cycle-latency read ports, then pulses done.
module mac_stage_engine
  import npu_pkg::*;
#(
  parameter int unsigned N_IN   = 132,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SHIFT  = 0,
  parameter bit          RELU   = 1'b1,
  localparam int unsigned IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned W_AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int unsigned OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [IN_AW-1:0]        in_addr,
  input  logic signed [7:0]       in_data,
  output logic [W_AW-1:0]         w_addr,
  input  logic signed [7:0]       w_data,
  output logic                    out_we,
  output logic [OUT_AW-1:0]       out_addr,
  output logic signed [7:0]       out_data,
  output logic                    busy,
  output logic                    done
);

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

  state_e                  state_q, state_d;
  logic [IN_AW-1:0]        i_q, i_d, in_addr_q, in_addr_d;
  logic [OUT_AW-1:0]       j_q, j_d;
  logic [W_AW-1:0]         w_addr_q, w_addr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [7:0]       out_data_q, out_data_d, rq;
  prod16_t                 prod;

  // Read data always belongs to the address issued one cycle earlier.
  assign prod    = in_data * w_data;
  assign acc_sum = acc_q + ACC_W'(prod);

  requant_sat8 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_requant (
    .acc (acc_sum),
    .q   (rq)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    acc_d      = acc_q;
    in_addr_d  = in_addr_q;
    w_addr_d   = w_addr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d     = '0;
          i_d       = '0;
          j_d       = '0;
          in_addr_d = '0;
          w_addr_d  = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_q != '0) acc_d = acc_sum;
        if (i_q == I_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          i_d       = i_q + 1'b1;
          in_addr_d = i_q + 1'b1;
          w_addr_d  = w_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Final sum is requantized here so out_data is a register during WRITE.
        acc_d      = acc_sum;
        out_data_d = rq;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        acc_d = '0;
        i_d   = '0;
        if (j_q == J_LAST) begin
          state_d = ST_DONE;
        end else begin
          j_d       = j_q + 1'b1;
          in_addr_d = '0;
          w_addr_d  = w_addr_q + 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_addr  = in_addr_q;
  assign w_addr   = w_addr_q;
  assign out_we   = (state_q == ST_WRITE);
  assign out_addr = j_q;
  assign out_data = out_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_stage_engine.sv
// Bench for mac_stage_engine: four parameterizations driven from bench-side
// memories, checked cycle by cycle against a dot-product reference model.
module tb_mac_stage_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nin  [4] = '{4, 4, 4, 132};
  int nout [4] = '{2, 2, 2, 10};
  int shf  [4] = '{0, 0, 4, 3};
  int rlu  [4] = '{0, 1, 0, 1};

  int checks   = 0;
  int failures = 0;
  int got [4][10];

  logic [3:0]        start = '0;
  logic [3:0]        out_we, busy, done;
  logic signed [7:0] out_data [4];
  logic signed [7:0] in_data  [4];
  logic signed [7:0] w_data   [4];
  logic signed [7:0] in_mem   [4][132];
  logic signed [7:0] w_mem    [4][1320];

  logic [1:0] ia0, ia1, ia2;
  logic [7:0] ia3;
  logic [2:0] wa0, wa1, wa2;
  logic [10:0] wa3;
  logic       oa0, oa1, oa2;
  logic [3:0] oa3;

  mac_stage_engine #(.N_IN(4), .N_OUT(2), .ACC_W(24), .SHIFT(0), .RELU(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_addr(ia0), .in_data(in_data[0]),
    .w_addr(wa0), .w_data(w_data[0]), .out_we(out_we[0]), .out_addr(oa0),
    .out_data(out_data[0]), .busy(busy[0]), .done(done[0]));
  mac_stage_engine #(.N_IN(4), .N_OUT(2), .ACC_W(24), .SHIFT(0), .RELU(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_addr(ia1), .in_data(in_data[1]),
    .w_addr(wa1), .w_data(w_data[1]), .out_we(out_we[1]), .out_addr(oa1),
    .out_data(out_data[1]), .busy(busy[1]), .done(done[1]));
  mac_stage_engine #(.N_IN(4), .N_OUT(2), .ACC_W(24), .SHIFT(4), .RELU(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .in_addr(ia2), .in_data(in_data[2]),
    .w_addr(wa2), .w_data(w_data[2]), .out_we(out_we[2]), .out_addr(oa2),
    .out_data(out_data[2]), .busy(busy[2]), .done(done[2]));
  mac_stage_engine #(.N_IN(132), .N_OUT(10), .ACC_W(24), .SHIFT(3), .RELU(1'b1)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .in_addr(ia3), .in_data(in_data[3]),
    .w_addr(wa3), .w_data(w_data[3]), .out_we(out_we[3]), .out_addr(oa3),
    .out_data(out_data[3]), .busy(busy[3]), .done(done[3]));

  // Synchronous read ports: data appears one cycle after the address.
  always @(posedge clk) begin
    in_data[0] <= in_mem[0][ia0];  w_data[0] <= w_mem[0][wa0];
    in_data[1] <= in_mem[1][ia1];  w_data[1] <= w_mem[1][wa1];
    in_data[2] <= in_mem[2][ia2];  w_data[2] <= w_mem[2][wa2];
    in_data[3] <= in_mem[3][ia3];  w_data[3] <= w_mem[3][wa3];
  end

  function automatic int oaddr(input int k);
    case (k)
      0: return int'(oa0);
      1: return int'(oa1);
      2: return int'(oa2);
      default: return int'(oa3);
    endcase
  endfunction

  // out[j] = relu?(clamp(floor(dot(in, w_j) / 2^shift), -128, 127))
  function automatic int model_out(input int k, input int j);
    longint s = 0;
    for (int i = 0; i < nin[k]; i++)
      s += longint'(in_mem[k][i]) * longint'(w_mem[k][j * nin[k] + i]);
    s = s >>> shf[k];
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (rlu[k] != 0 && s < 0) s = 0;
    return int'(s);
  endfunction

  function automatic int rnd8();
    case ($urandom_range(0, 5))
      0: return -128;
      1: return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic load_in(input int k, input int a0, input int a1, input int a2, input int a3);
    in_mem[k][0] = 8'(a0); in_mem[k][1] = 8'(a1);
    in_mem[k][2] = 8'(a2); in_mem[k][3] = 8'(a3);
  endtask

  task automatic load_w(input int k, input int j, input int a0, input int a1, input int a2, input int a3);
    w_mem[k][j*4+0] = 8'(a0); w_mem[k][j*4+1] = 8'(a1);
    w_mem[k][j*4+2] = 8'(a2); w_mem[k][j*4+3] = 8'(a3);
  endtask

  // Entered and left on a falling edge; c counts cycles after start is sampled.
  task automatic run_layer(input int k, input bit hold, input string tag);
    int  per, total, j;
    bit  we_e, dn_e, bs_e;
    per   = nin[k] + 2;
    total = nout[k] * per + 1;
    start[k] = 1'b1;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (!hold) start[k] = 1'b0;
      j    = c / per - 1;
      we_e = (c % per == 0) && (c <= nout[k] * per);
      dn_e = (c == total);
      bs_e = (c <= total);
      checks++;
      if (out_we[k] !== we_e || done[k] !== dn_e || busy[k] !== bs_e) begin
        failures++;
        $display("FAIL %s ctl c=%0d we=%b exp=%b done=%b exp=%b busy=%b exp=%b",
                 tag, c, out_we[k], we_e, done[k], dn_e, busy[k], bs_e);
      end
      if (we_e) begin
        got[k][j] = int'(out_data[k]);
        checks++;
        if (oaddr(k) !== j || int'(out_data[k]) !== model_out(k, j)) begin
          failures++;
          $display("FAIL %s write j=%0d addr=%0d exp=%0d data=%0d exp=%0d",
                   tag, j, oaddr(k), j, int'(out_data[k]), model_out(k, j));
        end
      end
    end
  endtask

  task automatic load_scen1(input int k);
    load_in(k, 1, 2, 3, 4);
    load_w(k, 0, 1, 1, 1, 1);
    load_w(k, 1, 2, 0, 0, -1);
  endtask

  task automatic check_pair(input int k, input int e0, input int e1, input string tag);
    checks++;
    if (got[k][0] !== e0 || got[k][1] !== e1) begin
      failures++;
      $display("FAIL %s out0=%0d exp=%0d out1=%0d exp=%0d", tag, got[k][0], e0, got[k][1], e1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 4'b0 || done !== 4'b0 || out_we !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl busy=%b done=%b we=%b exp=0000", busy, done, out_we);
    end
    checks++;
    if (ia0 !== 2'd0 || wa0 !== 3'd0 || oa0 !== 1'b0 || out_data[0] !== 8'sd0) begin
      failures++;
      $display("FAIL reset_regs in_addr=%0d w_addr=%0d out_addr=%0d out_data=%0d exp=0",
               ia0, wa0, oa0, out_data[0]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_scen1(0);
    run_layer(0, 1'b0, "basic");
    check_pair(0, 10, -2, "basic_vals");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 2; k++) begin
      load_in(k, 127, 127, 127, 127);
      load_w(k, 0, -128, -128, -128, -128);
      load_w(k, 1, 127, 127, 127, 127);
      run_layer(k, 1'b0, "sat");
    end
    check_pair(0, -128, 127, "sat_norelu");
    check_pair(1, 0, 127, "sat_relu");
  endtask

  task automatic test_shift();
    load_in(2, 10, 10, 10, 10);
    load_w(2, 0, 1, 1, 1, 1);
    load_w(2, 1, -1, -1, -1, -1);
    run_layer(2, 1'b0, "shift");
    check_pair(2, 2, -3, "shift_vals");
  endtask

  task automatic test_back_to_back();
    load_scen1(0);
    run_layer(0, 1'b1, "b2b_first");
    check_pair(0, 10, -2, "b2b_first_vals");
    got[0][0] = 0; got[0][1] = 0;
    run_layer(0, 1'b0, "b2b_second");
    check_pair(0, 10, -2, "b2b_second_vals");
  endtask

  task automatic test_reset_midrun();
    bit bs_e;
    load_scen1(0);
    start[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      bs_e = (c <= 3);
      checks++;
      if (busy[0] !== bs_e || out_we[0] !== 1'b0 || done[0] !== 1'b0) begin
        failures++;
        $display("FAIL midrst c=%0d busy=%b exp=%b we=%b done=%b exp=0",
                 c, busy[0], bs_e, out_we[0], done[0]);
      end
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
    end
    got[0][0] = 0; got[0][1] = 0;
    run_layer(0, 1'b0, "after_rst");
    check_pair(0, 10, -2, "after_rst_vals");
  endtask

  task automatic test_random();
    int k;
    for (int r = 0; r < 9; r++) begin
      k = r % 3;
      for (int i = 0; i < 4; i++) in_mem[k][i] = 8'(rnd8());
      for (int i = 0; i < 8; i++) w_mem[k][i] = 8'(rnd8());
      run_layer(k, 1'b0, "random");
    end
  endtask

  task automatic test_large();
    for (int i = 0; i < 132; i++) in_mem[3][i] = 8'sd1;
    for (int i = 0; i < 1320; i++) w_mem[3][i] = 8'sd1;
    run_layer(3, 1'b0, "large");
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[3][j] !== 16) begin
        failures++;
        $display("FAIL large_val j=%0d got=%0d exp=16", j, got[3][j]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 132; i++) in_mem[k][i] = '0;
      for (int i = 0; i < 1320; i++) w_mem[k][i] = '0;
      for (int j = 0; j < 10; j++) got[k][j] = 0;
    end
    test_reset();
    test_basic();
    test_saturate();
    test_shift();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    test_large();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
